booth_controller: RTL and testbench
===================================

# booth_controller

Sequencing FSM for the 4-bit Booth multiplier datapath. It drives the 2-bit control codes of the A, Q, M and Q-1 registers plus the adder/subtractor select, runs WIDTH add/shift iterations per multiply, and reports completion with a start/busy/done handshake. It sits between the top-level multiplier wrapper and the register/ALU datapath, and it holds no operand data.

## Interface
- WIDTH, 4, operand width; also the iteration count.
- CNT_W, 3, counter width; must satisfy 2^CNT_W > WIDTH.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a multiply; sampled only in IDLE.
- q0  in  1  current Q[0] from the Q register.
- qm1  in  1  current Q-1 bit.
- aCtrl  out  2  A register control.
- qCtrl  out  2  Q register control.
- mCtrl  out  2  M register control.
- qm1Ctrl  out  2  Q-1 flop control.
- aluSub  out  1  1 = A−M, 0 = A+M; meaningful only when aCtrl=LOAD.
- busy  out  1  high in INIT, EVAL and SHIFT.
- done  out  1  one-cycle pulse; product valid in {A,Q}.
- count  out  CNT_W  iterations remaining.

## Operation
- Register control encoding, shared by all datapath registers: LOAD=00, RESET=01, SHIFT=10, HOLD=11.
- Outputs are Moore-decoded from the state register. In every state, any ctrl output not listed below is HOLD and aluSub is 0.
- IDLE: busy=0, done=0. If start=1, go to INIT.
- INIT, one cycle: aCtrl=RESET, qm1Ctrl=RESET, qCtrl=LOAD (multiplier), mCtrl=LOAD (multiplicand). count loads WIDTH. Next state is EVAL.
- EVAL, one cycle, decoded from {q0,qm1}:
  - 10: aCtrl=LOAD, aluSub=1.
  - 01: aCtrl=LOAD, aluSub=0.
  - 00 or 11: aCtrl=HOLD.
  - Next state is SHIFT.
- SHIFT, one cycle: aCtrl=qCtrl=qm1Ctrl=SHIFT (arithmetic right shift of {A,Q,Q-1} is done in the datapath). mCtrl=HOLD. count decrements.
  - If count==1 before the decrement, go to DONE.
  - Otherwise go to EVAL.
- DONE, one cycle: done=1, busy=0, all ctrl HOLD. Next state is IDLE unconditionally.
- start is ignored in INIT, EVAL, SHIFT and DONE. There is no queuing.
- count stays 0 in DONE and IDLE, and never wraps below 0.
- Reset (any cycle, asynchronous):
  - State goes to IDLE and count to 0.
  - All ctrl outputs go to HOLD (11); aluSub, busy and done go to 0.
  - The datapath registers are not touched by this reset. The next INIT clears them.
- Reset released while start=1: INIT is entered on the first rising edge at which rst=0 and start=1.

## Timing
- Edge 0 samples start=1 in IDLE. Cycle numbering below counts edges after edge 0.
- INIT occupies cycle 1.
- EVAL occupies cycles 2, 4, …, 2·WIDTH; SHIFT occupies cycles 3, 5, …, 2·WIDTH+1.
- done is high in cycle 2·WIDTH+2, which is cycle 10 for WIDTH=4.
- Latency from start to done is 2·WIDTH+2 cycles. Minimum start-to-start spacing is 2·WIDTH+3 cycles, because IDLE lasts at least one cycle after DONE.
- q0/qm1 are sampled combinationally in EVAL and must be stable from the preceding SHIFT or INIT edge.
- count sequence during SHIFT cycles is 4, 3, 2, 1. It reads 0 from the DONE cycle on.

## Test plan
Benches use a behavioural A/Q/M/Q-1 model driven by the ctrl outputs.
- Reset: assert rst asynchronously mid-SHIFT in cycle 5 -> immediately all ctrl=11, busy=0, done=0, count=0; no done pulse afterwards.
- 0011 × 0010 with start pulsed 1 cycle:
  - EVAL decisions in order: HOLD, SUB, ADD, HOLD.
  - done pulses in cycle 10 with {A,Q}=00000110.
  - busy is high in cycles 1–9.
- 1101 × 0011 (−3×3) -> EVAL decisions SUB, HOLD, ADD, HOLD; done in cycle 10 with {A,Q}=11110111 (−9).
- start held high continuously -> DONE in cycle 10, IDLE in cycle 11, INIT in cycle 12; no extra done pulses; start pulses in cycles 3–9 are ignored.
- 0111 × 1000 -> EVAL decisions HOLD, HOLD, HOLD, SUB; {A,Q}=11001000 (−56).
- count trace for one multiply -> 4 in EVAL1, then decrementing to 0 at DONE; aluSub=0 in every cycle where aCtrl≠LOAD.

Source files
------------

// File: rtl/booth_controller.sv
// booth_controller: start/busy/done sequencer driving the A, Q, M and Q-1 register controls
// and the add/subtract select of a Booth multiplier datapath.
module booth_controller #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             q0,
  input  logic             qm1,
  output logic [1:0]       aCtrl,
  output logic [1:0]       qCtrl,
  output logic [1:0]       mCtrl,
  output logic [1:0]       qm1Ctrl,
  output logic             aluSub,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
);
  localparam logic [1:0] LOAD  = 2'b00;
  localparam logic [1:0] RESET = 2'b01;
  localparam logic [1:0] SHF   = 2'b10;
  localparam logic [1:0] HOLD  = 2'b11;
  typedef enum logic [2:0] {IDLE, INIT, EVAL, SHIFT, DONE} state_t;
  state_t state, next;
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next;
      cnt   <= state == INIT ? CNT_W'(WIDTH) :
               state == SHIFT ? (cnt != '0 ? cnt - CNT_W'(1) : '0) :
               state == EVAL ? cnt : '0;
    end
  // EVAL is the only state whose outputs look at the datapath: {q0,qm1}=10 subtracts, 01 adds
  always_comb begin
    next    = state;
    aCtrl   = HOLD;
    qCtrl   = HOLD;
    mCtrl   = HOLD;
    qm1Ctrl = HOLD;
    aluSub  = 1'b0;
    case (state)
      IDLE:  next = start ? INIT : IDLE;
      INIT: begin
        aCtrl   = RESET;
        qm1Ctrl = RESET;
        qCtrl   = LOAD;
        mCtrl   = LOAD;
        next    = EVAL;
      end
      EVAL: begin
        aCtrl  = q0 ^ qm1 ? LOAD : HOLD;
        aluSub = q0 & ~qm1;
        next   = SHIFT;
      end
      SHIFT: begin
        aCtrl   = SHF;
        qCtrl   = SHF;
        qm1Ctrl = SHF;
        next    = cnt == CNT_W'(1) ? DONE : EVAL;
      end
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end
  assign busy  = state == INIT || state == EVAL || state == SHIFT;
  assign done  = state == DONE;
  assign count = cnt;
endmodule

// File: tb/tb_booth_controller.sv
// tb_booth_controller: behavioural A/Q/M/Q-1 datapath around the controller, with a
// scoreboard of expected products and EVAL decisions checked by a done-driven monitor.
module tb_booth_controller;
  logic clk = 0, rst = 1, start = 0;
  logic [1:0] aCtrl, qCtrl, mCtrl, qm1Ctrl;
  logic aluSub, busy, done;
  logic [2:0] count;
  logic [3:0] A = 0, Q = 0, M = 0, mc = 0, mp = 0;
  logic Qm1 = 0;
  int total = 0, bad = 0, k = 0;
  bit active = 0;
  logic [7:0] dec = 0;
  typedef struct packed {logic [7:0] prod; logic [7:0] dec;} exp_t;
  exp_t sb[$];
  exp_t e;

  booth_controller #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .q0(Q[0]), .qm1(Qm1),
    .aCtrl(aCtrl), .qCtrl(qCtrl), .mCtrl(mCtrl), .qm1Ctrl(qm1Ctrl),
    .aluSub(aluSub), .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    A   <= aCtrl == 2'b00 ? (aluSub ? A - M : A + M) : aCtrl == 2'b01 ? 4'd0 :
           aCtrl == 2'b10 ? {A[3], A[3:1]} : A;
    Q   <= qCtrl == 2'b00 ? mp : qCtrl == 2'b10 ? {A[0], Q[3:1]} : Q;
    M   <= mCtrl == 2'b00 ? mc : M;
    Qm1 <= qm1Ctrl == 2'b01 ? 1'b0 : qm1Ctrl == 2'b10 ? Q[0] : Qm1;
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] code(input logic [1:0] a, input logic s);
    return a == 2'b00 ? (s ? 2'd1 : 2'd2) : a == 2'b11 ? 2'd0 : 2'd3;
  endfunction

  always @(negedge clk) begin
    if (!busy) chk("idle_ctrl", {aCtrl, qCtrl, mCtrl, qm1Ctrl, aluSub}, 9'h1FE);
    if (aCtrl != 2'b00) chk("alusub_zero", aluSub, 0);
    if (rst) active = 0;
    else begin
      if (busy && !active) begin
        active = 1;
        k = 0;
        dec = 0;
      end
      if (active) begin
        k++;
        if (k < 10) begin
          chk("busy", busy, 1);
          chk("count", count, k == 1 ? 0 : 4 - (k - 2) / 2);
        end
        if (k == 1) chk("init_ctrl", {aCtrl, qCtrl, mCtrl, qm1Ctrl}, 8'b01_00_00_01);
        else if (k < 10 && k % 2 == 1) chk("shift_ctrl", {aCtrl, qCtrl, mCtrl, qm1Ctrl}, 8'b10_10_11_10);
        else if (k < 10) begin
          chk("eval_ctrl", {qCtrl, mCtrl, qm1Ctrl}, 6'h3F);
          dec = {dec[5:0], code(aCtrl, aluSub)};
        end else begin
          chk("done_cycle", {busy, done, count}, {1'b0, 1'b1, 3'd0});
          active = 0;
        end
      end
      if (done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 expected no pulse at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("product", {A, Q}, e.prod);
          chk("decisions", dec, e.dec);
        end
      end
    end
  end

  task automatic run(input logic [3:0] m, input logic [3:0] q, input logic [7:0] p, input logic [7:0] d);
    @(negedge clk);
    mc = m;
    mp = q;
    sb.push_back({p, d});
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (14) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_state", {aCtrl, qCtrl, mCtrl, qm1Ctrl, aluSub, busy, done, count}, {8'hFF, 3'b000, 3'd0});
    rst = 0;
    // decisions coded HOLD=0 SUB=1 ADD=2, first decision in the top bits
    run(4'b0011, 4'b0010, 8'b0000_0110, 8'b00_01_10_00);
    run(4'b1101, 4'b0011, 8'b1111_0111, 8'b01_00_10_00);
    run(4'b0111, 4'b1000, 8'b1100_1000, 8'b00_00_00_01);
    // start held high: back-to-back multiplies with one IDLE cycle between
    @(negedge clk);
    mc = 4'b0010;
    mp = 4'b0011;
    sb.push_back({8'b0000_0110, 8'b01_00_10_00});
    sb.push_back({8'b0000_0110, 8'b01_00_10_00});
    start = 1;
    repeat (11) @(negedge clk);
    chk("held_idle11", {busy, done}, 2'b00);
    @(negedge clk);
    chk("held_init12", {busy, done}, 2'b10);
    start = 0;
    for (int c = 13; c <= 21; c++) begin
      @(negedge clk);
      start = c >= 14 && c <= 20 && c % 2 == 1;
    end
    repeat (6) @(negedge clk);
    // asynchronous reset in the middle of the cycle-5 SHIFT
    @(negedge clk);
    mc = 4'b0011;
    mp = 4'b0010;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(posedge clk);
    #2;
    chk("pre_rst_busy", {busy, count}, {1'b1, 3'd3});
    rst = 1;
    #1;
    chk("async_rst", {aCtrl, qCtrl, mCtrl, qm1Ctrl, aluSub, busy, done, count}, {8'hFF, 3'b000, 3'd0});
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    repeat (15) @(negedge clk);
    // reset released while start is already high
    @(negedge clk);
    rst = 1;
    mc = 4'b1101;
    mp = 4'b0011;
    sb.push_back({8'b1111_0111, 8'b01_00_10_00});
    start = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    start = 0;
    repeat (14) @(negedge clk);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
